// File: rtl/ifetch_controller.sv
// Instruction-fetch sequencer for a synchronous-read BRAM with a small skid FIFO toward decode.
// Optional macro IFETCH_PERF_EN adds perf_fetched / perf_stall counters.
//
//   state  | meaning
//   BOOT   | first cycle out of reset, nothing issued
//   RUN    | fetching while halt is low and credit allows
//   HALTED | no new fetches; in-flight read and FIFO still drain
module ifetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        busy
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q;
  logic            inflight_q;
  logic [31:0]     inflight_pc_q;
  logic [31:0]     fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic [31:0]     redirect_addr;
  logic            deq, push, issue;
  logic [CW:0]     credit_used;
  logic [1:0]      unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];
  assign redirect_addr = {redirect_pc[31:2], 2'b00};
  assign imem_addr     = redirect_valid ? redirect_addr : pc_q;

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? fifo_pc[rd_ptr_q]    : 32'h0;
  assign out_instr = out_valid ? fifo_instr[rd_ptr_q] : NOP;
  assign busy      = inflight_q | out_valid;

  assign deq  = out_valid & out_ready;
  assign push = inflight_q & ~redirect_valid;

  // Slots already spoken for once this cycle's pop is taken into account.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq};

  // A redirect flushes everything, so it never needs credit.
  assign issue = (state_q == RUN) && !halt &&
                 (redirect_valid || (credit_used < (CW+1)'(FIFO_DEPTH)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt)  state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= imem_addr;
        pc_q          <= imem_addr + 32'd4;
      end else if (redirect_valid) begin
        pc_q <= redirect_addr;
      end

      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr_q]    <= inflight_pc_q;
          fifo_instr[wr_ptr_q] <= imem_rdata;
          wr_ptr_q             <= wr_ptr_q + PW'(1);
        end
        if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push, deq})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (deq) perf_fetched <= perf_fetched + 32'd1;
      if ((state_q == RUN) && !out_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ifetch_controller.md
Name: ifetch_controller

Overview:
- Sequences the synchronous-read instruction BRAM: generates fetch addresses, tracks the single in-flight read, and buffers returned words.
- Presents a valid/ready instruction stream with PC to decode.
- Accepts PC redirects (branch/jump/trap) and a halt request.
- Sits in the IF stage, between the PC logic and the instruction memory / IF-ID boundary.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, output skid-buffer entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- halt  in  1  level; while high, no new fetches are issued
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0)
- imem_addr  out  32  byte address to instruction memory (combinational)
- imem_rdata  in  32  memory read data; valid one cycle after the address
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction word of head entry
- busy  out  1  in-flight read or FIFO non-empty

Behaviour:
- Registers and state:
  - pc_q: next PC to issue.
  - inflight_q, inflight_pc_q: one BRAM read outstanding.
  - FIFO of {pc, instr}; count 0..FIFO_DEPTH.
  - FSM: BOOT, RUN, HALTED.
- Reset (rst=1 at posedge), regardless of in-flight activity:
  - pc_q=RESET_PC, inflight_q=0, FIFO empty, state=BOOT.
  - out_valid=0, out_pc=0, out_instr=32'h00000013, busy=0.
- FSM transitions:
  - BOOT -> RUN after one cycle; no issue in BOOT.
  - RUN -> HALTED when halt=1.
  - HALTED -> RUN when halt=0.
  - In HALTED, the FIFO still drains and the in-flight read still completes.
- Address: imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q.
- Issue condition: state==RUN and halt==0 and (count + inflight_q - deq) < FIFO_DEPTH, where deq = out_valid & out_ready.
  - On issue: inflight_q<=1, inflight_pc_q<=imem_addr, pc_q<=imem_addr+4.
  - pc_q wraps 32'hFFFF_FFFC -> 0.
  - No issue: inflight_q<=0.
- Capture: when inflight_q=1 (and no redirect this cycle), push {inflight_pc_q, imem_rdata} into the FIFO this cycle. The credit rule guarantees space; overflow is impossible.
- Throughput and latency:
  - Sustains one instruction per cycle with out_ready held high.
  - Address issued in cycle N -> FIFO write at end of N+1 -> out_valid earliest in N+2.
- Output handshake: head is held stable while out_valid=1 and out_ready=0. Pop on out_valid & out_ready.
- Redirect:
  - Clears the FIFO and drops the in-flight read; its data is discarded.
  - Issues the redirect target in the same cycle if RUN and halt=0; otherwise pc_q<=target, with no issue.
  - A head accepted in the redirect cycle counts as consumed (older instruction).
  - out_pc=target appears two cycles after the redirect cycle.
- Redirect while HALTED: flushes and loads pc_q; fetch resumes from the target on halt deassert.
- Redirect in BOOT: loads pc_q; first fetch uses the target.
- Simultaneous push and pop on a full FIFO is legal; count unchanged.
- busy = inflight_q | (count!=0).

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds output ports perf_fetched [31:0] (increments on each pop) and perf_stall [31:0] (increments each cycle out_valid=0 in RUN).
  - Both counters reset to 0 on rst and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset release, out_ready=1, memory holds word = 0x1000+index -> first out_valid in cycle 3 after rst deasserted.
  - out_pc sequence is 0x0, 0x4, 0x8 with out_instr 0x1000, 0x1001, 0x1002.
  - One instruction per cycle thereafter.
- out_ready=0 for 5 cycles mid-stream -> FIFO fills to 2, issue stops, out_pc/out_instr stay stable.
  - On out_ready=1, the stream resumes with no duplicated or skipped PC.
- redirect_valid with redirect_pc=0x203 while FIFO holds 2 entries and a read is in flight -> no stale entry is emitted.
  - out_valid with out_pc=0x200 exactly two cycles later.
- halt=1 for 4 cycles -> no new fetches; in-flight and buffered instructions drain, then out_valid=0 and busy=0.
  - halt=0 resumes at the next sequential PC.
- rst asserted with a full FIFO and an in-flight read -> next cycle out_valid=0, busy=0.
  - Fetch restarts at RESET_PC.
- With IFETCH_PERF_EN: 10 accepted instructions plus 3 backpressure bubbles -> perf_fetched=10.
  - perf_stall counts the cycles with out_valid=0.
